fp32_add_result_stage: RTL and testbench
========================================

FP32_ADD_RESULT_STAGE -- requirements
Module: fp32_add_result_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: number of output buffer entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: the upstream FP32 adder result and operands are valid.
REQ-005 SHALL have port in_ready, output, 1: this stage accepts the input this cycle.
REQ-006 SHALL have port in_x, input, 32: original operand X, before any swap.
REQ-007 SHALL have port in_y, input, 32: original operand Y, before any swap.
REQ-008 SHALL have port in_r, input, 32: raw adder result {sign, exp, frac}.
REQ-009 SHALL have port in_exp_ovf, input, 1: the adder's updated exponent was at least 255 before truncation.
REQ-010 SHALL have port in_exp_unf, input, 1: the adder's updated exponent was at most 0, or the sum cancelled to exactly zero.
REQ-011 SHALL have port out_valid, output, 1: the buffer head is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes the head.
REQ-013 SHALL have port out_r, output, 32: final IEEE-754 single-precision result.
REQ-014 SHALL have port out_flags, output, 3: per-result flags {NV, OF, ZR}.
REQ-015 SHALL have port flags_clr, input, 1: synchronous clear of the accumulated flags.
REQ-016 SHALL have port fflags, output, 3: sticky OR of every out_flags value popped (present only when the macro in REQ-031 is defined).

Function
REQ-017 SHALL push one entry when in_valid and in_ready are both high; the push is a handshake.
REQ-018 SHALL pop the head when out_valid and out_ready are both high.
REQ-019 SHALL drive in_ready = (count < FIFO_DEPTH) from registered state only, with no combinational path from out_ready.
REQ-020 SHALL make the entry visible on out_valid, out_r and out_flags on cycle N+1 when pushed in cycle N into an empty buffer; there SHALL be no same-cycle bypass.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop, including when count equals FIFO_DEPTH-1; when full, a pop frees a slot that is visible from the next cycle.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH and preserve FIFO order.
REQ-023 SHALL select the output per entry, first match wins:
- a) Either operand is a NaN (exp=0xFF, frac!=0): result 0x7FC00000; NV=1 iff either NaN is signalling (frac[22]=0).
- b) Both operands are Inf with opposite signs: result 0x7FC00000, NV=1.
- c) Either operand is Inf: result is that Inf, flags 0.
- d) in_exp_ovf=1: result {in_r[31], 0xFF, 23'b0}, OF=1.
- e) in_exp_unf=1: result 0x00000000, ZR=1.
- f) Otherwise: result in_r; ZR=1 iff in_r[30:0]=0.
REQ-024 SHALL hold out_r and out_flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive out_r and out_flags to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, immediately force count=0, both pointers=0, out_valid=0, out_r=0, out_flags=0 and fflags=0.
REQ-027 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-028 SHALL discard all buffered entries on a mid-operation reset; none SHALL reappear after reset.

Configuration
REQ-029 SHALL set every fflags bit that is set in out_flags on each pop, in the same clock edge.
REQ-030 SHALL give flags_clr priority on a simultaneous clear and pop, so fflags becomes 0.
REQ-031 SHALL compile the accumulator of REQ-029/030 only when macro FP_ADD_FLAGS_EN is defined; without it, fflags and flags_clr SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-032 SHALL take the constants FP32_QNAN=0x7FC00000, FP32_EXP_MAX=0xFF and the flag bit indices from the shared FP package.
REQ-033 SHALL define the entry typedef (result 32 bits plus flags 3 bits) in the same shared FP package.
REQ-034 SHALL place the REQ-023 priority logic in one combinational sub-module, fp32_special_case, shared with future mul/fma result stages.

Verification
REQ-035 SHALL cover: in_x=0x3F800000, in_y=0x3F800000, in_r=0x40000000 -> out_r=0x40000000, flags=000, one cycle later.
REQ-036 SHALL cover: in_x=0x7F800001, in_y=0x3F800000 -> out_r=0x7FC00000, NV=1.
REQ-037 SHALL cover: in_x=0x7F800000, in_y=0xFF800000 -> out_r=0x7FC00000, NV=1; then in_x=0xFF800000, in_y=0x3F800000 -> out_r=0xFF800000, flags=000.
REQ-038 SHALL cover: in_exp_ovf=1, in_r=0x80123456 -> out_r=0xFF800000, OF=1; in_exp_unf=1 -> out_r=0x00000000, ZR=1.
REQ-039 SHALL cover: out_ready=0 while pushing 3 entries A,B,C -> in_ready low after A,B; release out_ready -> A,B,C popped in order, with a simultaneous push/pop keeping count constant.
REQ-040 SHALL cover: rst_n pulsed low with 2 entries buffered -> out_valid=0 immediately; after release in_ready=1 and no stale entry is output; with FP_ADD_FLAGS_EN, fflags=0.

Source files
------------

// File: rtl/fp32_add_result_stage_pkg.sv
// Shared FP32 definitions: constants, flag bit positions, buffer entry type
// and small classification helpers used by the add/mul/fma result stages.
package fp32_add_result_stage_pkg;

  localparam int unsigned FP32_W  = 32;
  localparam int unsigned FLAGS_W = 3;

  localparam logic [FP32_W-1:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]        FP32_EXP_MAX = 8'hFF;

  // Flag vector layout is {NV, OF, ZR}
  localparam int unsigned FLAG_NV = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_ZR = 0;

  typedef struct packed {
    logic [FP32_W-1:0]  result;
    logic [FLAGS_W-1:0] flags;
  } fpEntry_t;

  function automatic logic isNan(input logic [FP32_W-1:0] v);
    return (v[30:23] == FP32_EXP_MAX) && (v[22:0] != 23'b0);
  endfunction

  function automatic logic isSnan(input logic [FP32_W-1:0] v);
    return isNan(v) && !v[22];
  endfunction

  function automatic logic isInf(input logic [FP32_W-1:0] v);
    return (v[30:23] == FP32_EXP_MAX) && (v[22:0] == 23'b0);
  endfunction

endpackage

// File: rtl/fp32_add_result_stage_if.sv
// Handshake bus of the FP32 add result stage: upstream adder result in,
// final IEEE result out. slave = the stage, master = its environment.
interface fp32_add_result_stage_if;
  import fp32_add_result_stage_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [FP32_W-1:0]  in_x;
  logic [FP32_W-1:0]  in_y;
  logic [FP32_W-1:0]  in_r;
  logic               in_exp_ovf;
  logic               in_exp_unf;
  logic               out_valid;
  logic               out_ready;
  logic [FP32_W-1:0]  out_r;
  logic [FLAGS_W-1:0] out_flags;

  modport slave (
    input  in_valid, in_x, in_y, in_r, in_exp_ovf, in_exp_unf, out_ready,
    output in_ready, out_valid, out_r, out_flags
  );

  modport master (
    output in_valid, in_x, in_y, in_r, in_exp_ovf, in_exp_unf, out_ready,
    input  in_ready, out_valid, out_r, out_flags
  );
endinterface

// File: rtl/fp32_add_result_stage_special_case.sv
// fp32_special_case: combinational IEEE special-value resolution for an FP32
// result stage. NaN beats Inf beats exponent overflow beats underflow.
module fp32_special_case
  import fp32_add_result_stage_pkg::*;
(
  input  logic [FP32_W-1:0] x,
  input  logic [FP32_W-1:0] y,
  input  logic [FP32_W-1:0] r,
  input  logic              expOvf,
  input  logic              expUnf,
  output fpEntry_t          entry_c
);

  // First matching case selects result and flags
  always_comb begin
    entry_c = '0;
    if (isNan(x) || isNan(y)) begin
      entry_c.result          = FP32_QNAN;
      entry_c.flags[FLAG_NV]  = isSnan(x) || isSnan(y);
    end else if (isInf(x) && isInf(y) && (x[31] != y[31])) begin
      entry_c.result          = FP32_QNAN;
      entry_c.flags[FLAG_NV]  = 1'b1;
    end else if (isInf(x)) begin
      entry_c.result          = x;
    end else if (isInf(y)) begin
      entry_c.result          = y;
    end else if (expOvf) begin
      entry_c.result          = {r[31], FP32_EXP_MAX, 23'b0};
      entry_c.flags[FLAG_OF]  = 1'b1;
    end else if (expUnf) begin
      entry_c.flags[FLAG_ZR]  = 1'b1;
    end else begin
      entry_c.result          = r;
      entry_c.flags[FLAG_ZR]  = (r[30:0] == 31'b0);
    end
  end

endmodule

// File: rtl/fp32_add_result_stage.sv
// FP32 add result stage: resolves special cases and buffers results in a
// FIFO_DEPTH-entry output FIFO. in_ready depends only on registered count.
// Optional sticky flag accumulator (fflags/flags_clr) under FP_ADD_FLAGS_EN.
module fp32_add_result_stage
  import fp32_add_result_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fp32_add_result_stage_if.slave    bus
`ifdef FP_ADD_FLAGS_EN
  ,
  input  logic                      flags_clr,
  output logic [FLAGS_W-1:0]        fflags
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fpEntry_t            mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wrPtr;
  logic [PtrW-1:0]     rdPtr;
  logic [CntW-1:0]     count;
  fpEntry_t            newEntry_c;
  fpEntry_t            head_c;
  logic                push_c;
  logic                pop_c;

  fp32_special_case uSpecial (
    .x       (bus.in_x),
    .y       (bus.in_y),
    .r       (bus.in_r),
    .expOvf  (bus.in_exp_ovf),
    .expUnf  (bus.in_exp_unf),
    .entry_c (newEntry_c)
  );

  assign bus.in_ready  = (count < CntW'(FIFO_DEPTH));
  assign bus.out_valid = (count != '0);
  assign push_c        = bus.in_valid && bus.in_ready;
  assign pop_c         = bus.out_valid && bus.out_ready;

  // Head is forced to zero when empty so stale storage never shows
  assign head_c        = bus.out_valid ? mem[rdPtr] : '0;
  assign bus.out_r     = head_c.result;
  assign bus.out_flags = head_c.flags;

  // Entry storage; validity is tracked by count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem[wrPtr] <= newEntry_c;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push_c) wrPtr <= wrPtr + PtrW'(1);
      if (pop_c)  rdPtr <= rdPtr + PtrW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FP_ADD_FLAGS_EN
  // Sticky OR of popped flags; clear wins over a same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fflags <= '0;
    else if (flags_clr)  fflags <= '0;
    else if (pop_c)      fflags <= fflags | head_c.flags;
  end
`endif

endmodule

// File: tb/tb_fp32_add_result_stage.sv
// Directed self-checking bench for fp32_add_result_stage (FIFO_DEPTH=2).
module tb_fp32_add_result_stage;
  import fp32_add_result_stage_pkg::*;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        ovf;
    logic        unf;
    logic [31:0] er;
    logic [2:0]  ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vecCount = 0;
  int   errCount = 0;
`ifdef FP_ADD_FLAGS_EN
  logic       flags_clr = 1'b0;
  logic [2:0] fflags;
  logic [2:0] accFlags = 3'b000;
`endif

  always #5 clk = ~clk;

  fp32_add_result_stage_if bus();

  fp32_add_result_stage #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef FP_ADD_FLAGS_EN
    ,
    .flags_clr (flags_clr),
    .fflags    (fflags)
`endif
  );

  task automatic driveIn(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic ovf, input logic unf);
    bus.in_valid   = v;
    bus.in_x       = x;
    bus.in_y       = y;
    bus.in_r       = r;
    bus.in_exp_ovf = ovf;
    bus.in_exp_unf = unf;
  endtask

  task automatic test_reset();
    driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vecCount++;
    if ({bus.out_valid, bus.out_r, bus.out_flags} !== 36'h0) begin
      errCount++;
      $display("FAIL reset_outputs got v=%b r=%h f=%b want 0", bus.out_valid, bus.out_r, bus.out_flags);
    end
`ifdef FP_ADD_FLAGS_EN
    vecCount++;
    if (fflags !== 3'b000) begin
      errCount++;
      $display("FAIL reset_fflags got %b want 000", fflags);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errCount++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_special_cases();
    vec_t v [12];
    v[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40000000, 3'b000};
    v[1]  = '{32'h7F800001, 32'h3F800000, 32'h12345678, 1'b0, 1'b0, 32'h7FC00000, 3'b100};
    v[2]  = '{32'h7FC00000, 32'h3F800000, 32'h12345678, 1'b0, 1'b0, 32'h7FC00000, 3'b000};
    v[3]  = '{32'h7F800000, 32'hFF800001, 32'h12345678, 1'b0, 1'b0, 32'h7FC00000, 3'b100};
    v[4]  = '{32'h7F800000, 32'hFF800000, 32'h00000000, 1'b0, 1'b0, 32'h7FC00000, 3'b100};
    v[5]  = '{32'hFF800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 32'hFF800000, 3'b000};
    v[6]  = '{32'h7F800000, 32'h7F800000, 32'h00000000, 1'b1, 1'b0, 32'h7F800000, 3'b000};
    v[7]  = '{32'h3F800000, 32'h3F800000, 32'h80123456, 1'b1, 1'b0, 32'hFF800000, 3'b010};
    v[8]  = '{32'h3F800000, 32'hBF800000, 32'h00400000, 1'b0, 1'b1, 32'h00000000, 3'b001};
    v[9]  = '{32'h3F800000, 32'h3F800000, 32'h00000001, 1'b1, 1'b1, 32'h7F800000, 3'b010};
    v[10] = '{32'h3F800000, 32'hBF800000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 3'b001};
    v[11] = '{32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 3'b000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      driveIn(1'b1, v[i].x, v[i].y, v[i].r, v[i].ovf, v[i].unf);
      #1;
      vecCount++;
      if (bus.out_valid !== 1'b0) begin
        errCount++;
        $display("FAIL sc%0d_no_bypass got out_valid=%b want 0", i, bus.out_valid);
      end
      @(posedge clk);
      #1;
      driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      vecCount++;
      if (bus.out_valid !== 1'b1 || bus.out_r !== v[i].er || bus.out_flags !== v[i].ef) begin
        errCount++;
        $display("FAIL sc%0d_result got v=%b r=%h f=%b want 1 %h %b",
                 i, bus.out_valid, bus.out_r, bus.out_flags, v[i].er, v[i].ef);
      end
`ifdef FP_ADD_FLAGS_EN
      accFlags = accFlags | v[i].ef;
`endif
      @(posedge clk);
      #1;
      vecCount++;
      if (bus.out_valid !== 1'b0 || bus.out_r !== 32'h0 || bus.out_flags !== 3'b000) begin
        errCount++;
        $display("FAIL sc%0d_drain got v=%b r=%h f=%b want 0", i, bus.out_valid, bus.out_r, bus.out_flags);
      end
    end
`ifdef FP_ADD_FLAGS_EN
    vecCount++;
    if (fflags !== accFlags) begin
      errCount++;
      $display("FAIL fflags_accum got %b want %b", fflags, accFlags);
    end
`endif
  endtask

`ifdef FP_ADD_FLAGS_EN
  task automatic test_flags_clr();
    @(negedge clk) flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    vecCount++;
    if (fflags !== 3'b000) begin
      errCount++;
      $display("FAIL flags_clr got %b want 000", fflags);
    end
    bus.out_ready = 1'b0;
    driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h00000005, 1'b1, 1'b0);
    @(posedge clk);
    #1 driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    vecCount++;
    if (fflags !== 3'b000 || bus.out_valid !== 1'b0) begin
      errCount++;
      $display("FAIL clr_vs_pop got fflags=%b v=%b want 000/0", fflags, bus.out_valid);
    end
    driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h00000005, 1'b1, 1'b0);
    @(posedge clk);
    #1 driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    vecCount++;
    if (fflags !== 3'b010) begin
      errCount++;
      $display("FAIL pop_sets_of got %b want 010", fflags);
    end
  endtask
`endif

  task automatic test_back_to_back();
    @(negedge clk);
    bus.out_ready = 1'b0;
    driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h11111111, 1'b0, 1'b0);
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b1) begin
      errCount++;
      $display("FAIL b2b_ready_a got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1 driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h22222222, 1'b0, 1'b0);
    vecCount++;
    if (bus.in_ready !== 1'b1 || bus.out_r !== 32'h11111111) begin
      errCount++;
      $display("FAIL b2b_after_a got rdy=%b r=%h want 1 11111111", bus.in_ready, bus.out_r);
    end
    @(posedge clk);
    #1 driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h33333333, 1'b0, 1'b0);
    vecCount++;
    if (bus.in_ready !== 1'b0 || bus.out_r !== 32'h11111111) begin
      errCount++;
      $display("FAIL b2b_full got rdy=%b r=%h want 0 11111111", bus.in_ready, bus.out_r);
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_r !== 32'h11111111 || bus.out_flags !== 3'b000) begin
      errCount++;
      $display("FAIL b2b_hold got rdy=%b v=%b r=%h f=%b want 0 1 11111111 000",
               bus.in_ready, bus.out_valid, bus.out_r, bus.out_flags);
    end
    bus.out_ready = 1'b1;
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b0) begin
      errCount++;
      $display("FAIL b2b_no_comb_ready got %b want 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b1 || bus.out_r !== 32'h22222222) begin
      errCount++;
      $display("FAIL b2b_pop_a got rdy=%b r=%h want 1 22222222", bus.in_ready, bus.out_r);
    end
    @(posedge clk);
    #1 driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecCount++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_r !== 32'h33333333) begin
      errCount++;
      $display("FAIL b2b_push_pop got rdy=%b v=%b r=%h want 1 1 33333333",
               bus.in_ready, bus.out_valid, bus.out_r);
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errCount++;
      $display("FAIL b2b_empty got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h44444444, 1'b1, 1'b0);
    @(posedge clk);
    #1 driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h55555555, 1'b0, 1'b0);
    @(posedge clk);
    #1 driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecCount++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errCount++;
      $display("FAIL mid_prefill got v=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (bus.out_valid !== 1'b0 || bus.out_r !== 32'h0 || bus.out_flags !== 3'b000) begin
      errCount++;
      $display("FAIL mid_reset_async got v=%b r=%h f=%b want 0", bus.out_valid, bus.out_r, bus.out_flags);
    end
`ifdef FP_ADD_FLAGS_EN
    vecCount++;
    if (fflags !== 3'b000) begin
      errCount++;
      $display("FAIL mid_reset_fflags got %b want 000", fflags);
    end
`endif
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errCount++;
      $display("FAIL mid_release got rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vecCount++;
      if (bus.out_valid !== 1'b0) begin
        errCount++;
        $display("FAIL mid_stale%0d got out_valid=%b r=%h want 0", i, bus.out_valid, bus.out_r);
      end
    end
    driveIn(1'b1, 32'h3F800000, 32'h3F800000, 32'h66666666, 1'b0, 1'b0);
    @(posedge clk);
    #1 driveIn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecCount++;
    if (bus.out_valid !== 1'b1 || bus.out_r !== 32'h66666666) begin
      errCount++;
      $display("FAIL mid_fresh got v=%b r=%h want 1 66666666", bus.out_valid, bus.out_r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_special_cases();
`ifdef FP_ADD_FLAGS_EN
    test_flags_clr();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
